// File: rtl/rx_pkg.sv
// Shared receive-chain constants, bank state type and the BPSK deinterleave
// index function (input bit j -> output position k).
package rx_pkg;

    localparam int N_CBPS_BPSK = 48;
    localparam int INTLV_COLS  = 16;

    typedef enum logic {
        BANK_EMPTY = 1'b0,
        BANK_FULL  = 1'b1
    } bank_state_t;

    // Output position of interleaved input bit j within one symbol.
    function automatic int deintlv_index(input int j, input int n_cbps = N_CBPS_BPSK);
        return INTLV_COLS * j - (n_cbps - 1) * ((INTLV_COLS * j) / n_cbps);
    endfunction

endpackage

// File: rtl/deintlv_addr_gen.sv
// Read-side address generator: walks col 0..15 fastest, then row, producing
// addr = ROWS*col + row by accumulation instead of multiplication.
module deintlv_addr_gen
    import rx_pkg::*;
#(
    parameter int N_CBPS = N_CBPS_BPSK,
    parameter int AW     = $clog2(N_CBPS)
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          step,
    input  logic          clear,
    output logic [AW-1:0] addr,
    output logic          last
);

    localparam int            ROWS     = N_CBPS / INTLV_COLS;
    localparam logic [AW-1:0] ROW_STEP = AW'(ROWS);
    localparam logic [AW-1:0] ROW_LAST = AW'(ROWS - 1);
    localparam logic [3:0]    COL_LAST = 4'(INTLV_COLS - 1);

    logic [3:0]    col;
    logic [AW-1:0] row;

    assign last = (col == COL_LAST) && (row == ROW_LAST);

    // Column advances every step; on column wrap the address reloads to the next row.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            col  <= '0;
            row  <= '0;
            addr <= '0;
        end else if (clear) begin
            col  <= '0;
            row  <= '0;
            addr <= '0;
        end else if (step) begin
            if (col == COL_LAST) begin
                col  <= '0;
                row  <= row + 1'b1;
                addr <= row + 1'b1;
            end else begin
                col  <= col + 1'b1;
                addr <= addr + ROW_STEP;
            end
        end
    end

endmodule

// File: rtl/bpsk_deinterleaver.sv
// Ping-pong BPSK block deinterleaver: one bank fills in arrival order while
// the other drains through the permuted read address, one bit per clock.
module bpsk_deinterleaver
    import rx_pkg::*;
#(
    parameter int N_CBPS = N_CBPS_BPSK
) (
    input  logic Clock,
    input  logic Reset,
    input  logic Input,
    input  logic InValid,
    output logic InReady,
    output logic Output,
    output logic OutValid,
    input  logic OutReady,
    output logic SymbolEnd
);

    localparam int            AW        = $clog2(N_CBPS);
    localparam logic [AW-1:0] WCNT_LAST = AW'(N_CBPS - 1);

    logic [N_CBPS-1:0] bank_mem [2];
    logic [1:0]        bank_full;
    logic              wbank;
    logic              rbank;
    logic [AW-1:0]     wcnt;
    logic [AW-1:0]     rd_addr;
    logic              rd_last;
    logic              wr_en;
    logic              wr_last;
    logic              rd_en;

    assign InReady = !bank_full[wbank];
    assign wr_en   = InValid && InReady;
    assign wr_last = wr_en && (wcnt == WCNT_LAST);
    assign rd_en   = (!OutValid || OutReady) && bank_full[rbank];

    // Write counter and bank pointer: switch banks after the last bit of a symbol.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            wcnt  <= '0;
            wbank <= 1'b0;
        end else if (wr_en) begin
            if (wcnt == WCNT_LAST) begin
                wcnt  <= '0;
                wbank <= ~wbank;
            end else begin
                wcnt <= wcnt + 1'b1;
            end
        end
    end

    // Bank storage needs no reset: contents are only read once a bank is FULL.
    always_ff @(posedge Clock) begin
        if (wr_en) begin
            bank_mem[wbank][wcnt] <= Input;
        end
    end

    // Per-bank EMPTY/FULL flag; fill and drain always target different banks.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_bank
            localparam logic BANK_ID = 1'(gi);
            bank_state_t state_reg;

            always_ff @(posedge Clock or negedge Reset) begin
                if (!Reset) begin
                    state_reg <= BANK_EMPTY;
                end else if (wr_last && (wbank == BANK_ID)) begin
                    state_reg <= BANK_FULL;
                end else if (rd_en && rd_last && (rbank == BANK_ID)) begin
                    state_reg <= BANK_EMPTY;
                end
            end

            assign bank_full[gi] = (state_reg == BANK_FULL);
        end
    endgenerate

    // Read bank pointer toggles once the final position of a symbol is loaded.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            rbank <= 1'b0;
        end else if (rd_en && rd_last) begin
            rbank <= ~rbank;
        end
    end

    // The generator rewinds on the last position so the next symbol starts at address 0.
    deintlv_addr_gen #(
        .N_CBPS(N_CBPS),
        .AW    (AW)
    ) u_addr_gen (
        .Clock(Clock),
        .Reset(Reset),
        .step (rd_en && !rd_last),
        .clear(rd_en && rd_last),
        .addr (rd_addr),
        .last (rd_last)
    );

    // Output register: load when free and a bank is full, else drop valid once consumed.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            Output    <= 1'b0;
            OutValid  <= 1'b0;
            SymbolEnd <= 1'b0;
        end else if (rd_en) begin
            Output    <= bank_mem[rbank][rd_addr];
            OutValid  <= 1'b1;
            SymbolEnd <= rd_last;
        end else if (OutReady) begin
            OutValid  <= 1'b0;
            SymbolEnd <= 1'b0;
        end
    end

    // A stalled output must not change under the consumer.
    a_hold_stable: assert property (
        @(posedge Clock) disable iff (!Reset)
        (OutValid && !OutReady) |=> (OutValid && $stable(Output) && $stable(SymbolEnd))
    );

endmodule

// File: tb/tb_bpsk_deinterleaver.sv
// Self-checking bench for bpsk_deinterleaver: random streams scored against a
// symbol-level permutation model built from deintlv_index.
module tb_bpsk_deinterleaver;
    import rx_pkg::*;

    localparam int N = N_CBPS_BPSK;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_bit = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic in_ready;
    logic out_bit;
    logic out_valid;
    logic sym_end;

    always #5 clk = ~clk;

    bpsk_deinterleaver #(.N_CBPS(N)) dut (
        .Clock    (clk),
        .Reset    (rst_n),
        .Input    (in_bit),
        .InValid  (in_valid),
        .InReady  (in_ready),
        .Output   (out_bit),
        .OutValid (out_valid),
        .OutReady (out_ready),
        .SymbolEnd(sym_end)
    );

    int total = 0;
    int bad = 0;
    int edge_n = 0;

    always @(posedge clk) edge_n++;

    // Model state
    bit         in_buf[$];
    logic [1:0] exp_q[$];   // {symbol_end, bit}
    logic [1:0] obs_q[$];
    int acc_cnt;
    int first_sym_edge;
    int first_valid_edge;
    int inready_low;
    int stall_viol;
    int rise_edge;
    int se_edge;
    int sym_out;
    bit hold_pending;
    logic hold_out;
    logic hold_se;

    task automatic model_reset();
        in_buf.delete();
        exp_q.delete();
        obs_q.delete();
        acc_cnt = 0;
        first_sym_edge = -1;
        first_valid_edge = -1;
        inready_low = 0;
        stall_viol = 0;
        rise_edge = -1;
        se_edge = -1;
        sym_out = 0;
        hold_pending = 0;
    endtask

    // One clock: observe handshakes at the falling edge, return just after the rising edge.
    task automatic tick();
        logic [1:0] sym [N];
        @(negedge clk);
        if (hold_pending && (out_valid !== 1'b1 || out_bit !== hold_out || sym_end !== hold_se))
            stall_viol++;
        hold_pending = out_valid && !out_ready;
        hold_out = out_bit;
        hold_se = sym_end;
        if (out_valid === 1'b1 && first_valid_edge < 0) first_valid_edge = edge_n;
        if (in_ready === 1'b1 && rise_edge < 0) rise_edge = edge_n;
        if (out_valid === 1'b1 && sym_end === 1'b1 && se_edge < 0) se_edge = edge_n;
        if (in_ready !== 1'b1) inready_low++;
        if (in_valid && in_ready === 1'b1) begin
            in_buf.push_back(in_bit);
            acc_cnt++;
            if (acc_cnt == N) first_sym_edge = edge_n;
            if (in_buf.size() == N) begin
                for (int j = 0; j < N; j++)
                    sym[deintlv_index(j, N)] = {1'b0, in_buf[j]};
                sym[N-1][1] = 1'b1;
                for (int k = 0; k < N; k++) exp_q.push_back(sym[k]);
                in_buf.delete();
            end
        end
        if (out_valid === 1'b1 && out_ready) begin
            obs_q.push_back({sym_end, out_bit});
            if (sym_end === 1'b1) begin
                sym_out++;
                $display("output symbol %0d complete at edge %0d", sym_out, edge_n);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        in_valid = 1'b0;
        out_ready = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        rst_n = 1'b1;
    endtask

    function automatic int count_mismatch(output int first_idx);
        int m = 0;
        first_idx = -1;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            if (obs_q[i] !== exp_q[i]) begin
                m++;
                if (first_idx < 0) first_idx = i;
            end
        end
        return m;
    endfunction

    task automatic drain(input int target, input bit random_ready, input int limit);
        in_valid = 1'b0;
        for (int c = 0; c < limit && obs_q.size() < target; c++) begin
            out_ready = random_ready ? 1'($urandom % 2) : 1'b1;
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (out_bit !== 1'b0)   begin bad++; $display("FAIL reset_output got=%b want=0", out_bit); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_outvalid got=%b want=0", out_valid); end
        total++; if (sym_end !== 1'b0)   begin bad++; $display("FAIL reset_symend got=%b want=0", sym_end); end
        total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL reset_inready got=%b want=1", in_ready); end
        model_reset();
        rst_n = 1'b1;
        $display("test_reset done");
    endtask

    task automatic test_onehot();
        int js[4]   = '{1, 3, 47, 0};
        int want[4] = '{16, 1, 47, 0};
        int ones, pos, fi, m;
        for (int t = 0; t < 4; t++) begin
            apply_reset();
            out_ready = 1'b1;
            for (int i = 0; i < N; i++) begin
                in_valid = 1'b1;
                in_bit = (i == js[t]);
                tick();
            end
            drain(N, 1'b0, 200);
            total++;
            if (obs_q.size() != N) begin
                bad++; $display("FAIL onehot_count j=%0d got=%0d want=%0d", js[t], obs_q.size(), N);
            end else begin
                ones = 0; pos = -1;
                for (int k = 0; k < N; k++) if (obs_q[k][0]) begin ones++; pos = k; end
                total++; if (ones != 1) begin bad++; $display("FAIL onehot_ones j=%0d got=%0d want=1", js[t], ones); end
                total++; if (pos != want[t]) begin bad++; $display("FAIL onehot_pos j=%0d got=%0d want=%0d", js[t], pos, want[t]); end
                total++; if (obs_q[N-1][1] !== 1'b1) begin bad++; $display("FAIL onehot_symend j=%0d got=%b want=1", js[t], obs_q[N-1][1]); end
                m = count_mismatch(fi);
                total++; if (m != 0) begin bad++; $display("FAIL onehot_model j=%0d mismatches=%0d want=0", js[t], m); end
            end
            $display("test_onehot j=%0d done", js[t]);
        end
    endtask

    task automatic test_stream();
        int fi, m;
        apply_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 3 * N; i++) begin
            in_valid = 1'b1;
            in_bit = 1'($urandom % 2);
            tick();
        end
        total++; if (inready_low != 0) begin bad++; $display("FAIL stream_inready_low got=%0d want=0", inready_low); end
        drain(3 * N, 1'b0, 400);
        total++; if (obs_q.size() != 3 * N) begin bad++; $display("FAIL stream_count got=%0d want=%0d", obs_q.size(), 3 * N); end
        m = count_mismatch(fi);
        total++;
        if (m != 0) begin
            bad++; $display("FAIL stream_data mismatches=%0d first=%0d got=%b want=%b", m, fi, obs_q[fi], exp_q[fi]);
        end
        total++;
        if (first_valid_edge - first_sym_edge != 2) begin
            bad++; $display("FAIL stream_latency got=%0d want=2", first_valid_edge - first_sym_edge);
        end
        $display("test_stream done: %0d bits", obs_q.size());
    endtask

    task automatic test_backpressure();
        int fi, m;
        apply_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 110; i++) begin
            in_valid = 1'b1;
            in_bit = 1'($urandom % 2);
            tick();
        end
        total++; if (acc_cnt != 2 * N) begin bad++; $display("FAIL bp_accepted got=%0d want=%0d", acc_cnt, 2 * N); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_inready got=%b want=0", in_ready); end
        rise_edge = -1;
        se_edge = -1;
        out_ready = 1'b1;
        for (int c = 0; c < 400 && acc_cnt < 3 * N; c++) begin
            in_valid = 1'b1;
            in_bit = 1'($urandom % 2);
            tick();
        end
        total++;
        if (rise_edge < 0 || rise_edge != se_edge) begin
            bad++; $display("FAIL bp_inready_rise got_edge=%0d want_edge=%0d", rise_edge, se_edge);
        end
        drain(3 * N, 1'b0, 400);
        total++; if (obs_q.size() != 3 * N) begin bad++; $display("FAIL bp_count got=%0d want=%0d", obs_q.size(), 3 * N); end
        m = count_mismatch(fi);
        total++;
        if (m != 0) begin
            bad++; $display("FAIL bp_data mismatches=%0d first=%0d got=%b want=%b", m, fi, obs_q[fi], exp_q[fi]);
        end
        total++; if (stall_viol != 0) begin bad++; $display("FAIL bp_stable violations=%0d want=0", stall_viol); end
        $display("test_backpressure done: %0d bits", obs_q.size());
    endtask

    task automatic test_random_stalls();
        int fi, m;
        apply_reset();
        for (int c = 0; c < 20000 && acc_cnt < 20 * N; c++) begin
            in_valid = 1'($urandom % 2);
            in_bit = 1'($urandom % 2);
            out_ready = 1'($urandom % 2);
            tick();
        end
        total++; if (acc_cnt != 20 * N) begin bad++; $display("FAIL stall_accepted got=%0d want=%0d", acc_cnt, 20 * N); end
        drain(20 * N, 1'b1, 5000);
        total++; if (obs_q.size() != 20 * N) begin bad++; $display("FAIL stall_count got=%0d want=%0d", obs_q.size(), 20 * N); end
        m = count_mismatch(fi);
        total++;
        if (m != 0) begin
            bad++; $display("FAIL stall_data mismatches=%0d first=%0d got=%b want=%b", m, fi, obs_q[fi], exp_q[fi]);
        end
        total++; if (stall_viol != 0) begin bad++; $display("FAIL stall_stable violations=%0d want=0", stall_viol); end
        $display("test_random_stalls done: %0d bits", obs_q.size());
    endtask

    task automatic test_reset_mid();
        int fi, m;
        apply_reset();
        out_ready = 1'b1;
        for (int i = 0; i < N + 30; i++) begin
            in_valid = 1'b1;
            in_bit = 1'($urandom % 2);
            tick();
        end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL mid_pre_valid got=%b want=1", out_valid); end
        rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_async_valid got=%b want=0", out_valid); end
        total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL mid_async_inready got=%b want=1", in_ready); end
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) begin
            in_valid = 1'b1;
            in_bit = 1'($urandom % 2);
            tick();
        end
        drain(N, 1'b0, 200);
        repeat (20) tick();
        total++; if (obs_q.size() != N) begin bad++; $display("FAIL mid_count got=%0d want=%0d", obs_q.size(), N); end
        m = count_mismatch(fi);
        total++;
        if (m != 0) begin
            bad++; $display("FAIL mid_data mismatches=%0d first=%0d got=%b want=%b", m, fi, obs_q[fi], exp_q[fi]);
        end
        $display("test_reset_mid done: %0d bits", obs_q.size());
    endtask

    initial begin
        model_reset();
        test_reset();
        test_onehot();
        test_stream();
        test_backpressure();
        test_random_stalls();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
